ts_pack_8ton: RTL and testbench

Parametrised byte-to-word packer for the transport-stream path. It accepts a 9-bit byte stream, with bit 8 as the start-of-packet flag, and packs it MSB-first into words of `OUT_BYTES` bytes. Each output word carries a start flag and a valid-byte count. A new packet start, or an optional idle timeout, flushes a partially filled word. The block generalises the fixed 8-to-32 packer and sits between the byte-wide TS receive stage and the wide split/PCIe datapath.

---
 rtl/ts_pack_8ton.sv | 116 +++++++++++
 tb/tb_ts_pack_8ton.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ts_pack_8ton.sv
// Packs a 9-bit TS byte stream (bit 8 = start of packet) MSB-first into OUT_BYTES-wide words with start flag and byte count.
// Latency: one registered cycle from the accepting edge; `TS_PACK_FLUSH_EN` adds an idle-timeout flush of partial words.
// Backpressure: none, every byte with ts_din_en high is accepted and at most one word leaves per cycle.
module ts_pack_8ton #(
  parameter int OUT_BYTES = 4,
  parameter int FLUSH_GAP = 2
) (
  input  logic                       clk_main,
  input  logic                       rst_n,
  input  logic [8:0]                 ts_din,
  input  logic                       ts_din_en,
  output logic [8*OUT_BYTES:0]       ts_dout,
  output logic                       ts_dout_en,
  output logic [$clog2(OUT_BYTES):0] ts_dout_cnt
);

  localparam int DW = 8 * OUT_BYTES;
  localparam int CW = $clog2(OUT_BYTES) + 1;

  generate
    if (OUT_BYTES < 2 || OUT_BYTES > 16 || FLUSH_GAP < 1 || FLUSH_GAP > 255) begin : g_param_check
      $error("ts_pack_8ton: OUT_BYTES or FLUSH_GAP out of range");
    end
  endgenerate

  logic [DW-1:0] data;
  logic [CW-1:0] fill;
  logic          sop_pend;

  logic [DW-1:0] lane_byte;
  logic [DW-1:0] data_nxt;
  logic [CW-1:0] fill_nxt;
  logic          sop_nxt;
  logic          emit;
  logic [DW-1:0] emit_word;
  logic [CW-1:0] emit_cnt;

`ifdef TS_PACK_FLUSH_EN
  logic [7:0] idle_cnt;
`endif

  // Incoming byte placed in lane `fill`; lane 0 is the most significant byte.
  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (fill == CW'(i)) lane_byte[8*(OUT_BYTES-i)-1 -: 8] = ts_din[7:0];
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_word = data;
    emit_cnt  = fill;
    data_nxt  = data;
    fill_nxt  = fill;
    sop_nxt   = sop_pend;
    if (ts_din_en) begin
      if (ts_din[8]) begin
        // A start byte always opens a fresh word, so flushing the old one cannot collide.
        emit     = (fill != '0);
        data_nxt = {ts_din[7:0], {(DW-8){1'b0}}};
        fill_nxt = CW'(1);
        sop_nxt  = 1'b1;
      end else if (fill == CW'(OUT_BYTES - 1)) begin
        emit      = 1'b1;
        emit_word = data | lane_byte;
        emit_cnt  = CW'(OUT_BYTES);
        data_nxt  = '0;
        fill_nxt  = '0;
        sop_nxt   = 1'b0;
      end else begin
        data_nxt = data | lane_byte;
        fill_nxt = fill + CW'(1);
      end
    end
`ifdef TS_PACK_FLUSH_EN
    else if (fill != '0 && idle_cnt == 8'(FLUSH_GAP - 1)) begin
      emit     = 1'b1;
      data_nxt = '0;
      fill_nxt = '0;
      sop_nxt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      data        <= '0;
      fill        <= '0;
      sop_pend    <= 1'b0;
      ts_dout     <= '0;
      ts_dout_en  <= 1'b0;
      ts_dout_cnt <= '0;
`ifdef TS_PACK_FLUSH_EN
      idle_cnt    <= '0;
`endif
    end else begin
      data       <= data_nxt;
      fill       <= fill_nxt;
      sop_pend   <= sop_nxt;
      ts_dout_en <= emit;
      if (emit) begin
        ts_dout     <= {sop_pend, emit_word};
        ts_dout_cnt <= emit_cnt;
      end
`ifdef TS_PACK_FLUSH_EN
      if (ts_din_en) begin
        idle_cnt <= '0;
      end else if (fill != '0 && idle_cnt != 8'(FLUSH_GAP)) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ts_pack_8ton.sv
// Directed bench for ts_pack_8ton: a 4-byte and an 8-byte instance share one input stream.
module tb_ts_pack_8ton;

  logic        clk_main = 1'b0;
  logic        rst_n = 1'b1;
  logic [8:0]  ts_din = '0;
  logic        ts_din_en = 1'b0;

  logic [32:0] d4_dout;
  logic        d4_en;
  logic [2:0]  d4_cnt;
  logic [64:0] d8_dout;
  logic        d8_en;
  logic [3:0]  d8_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [32:0] q4_dat[$];
  logic [2:0]  q4_cnt[$];
  int          q4_cyc[$];
  logic [64:0] q8_dat[$];
  logic [3:0]  q8_cnt[$];

  ts_pack_8ton #(.OUT_BYTES(4), .FLUSH_GAP(2)) dut4 (
    .clk_main(clk_main), .rst_n(rst_n), .ts_din(ts_din), .ts_din_en(ts_din_en),
    .ts_dout(d4_dout), .ts_dout_en(d4_en), .ts_dout_cnt(d4_cnt)
  );

  ts_pack_8ton #(.OUT_BYTES(8), .FLUSH_GAP(2)) dut8 (
    .clk_main(clk_main), .rst_n(rst_n), .ts_din(ts_din), .ts_din_en(ts_din_en),
    .ts_dout(d8_dout), .ts_dout_en(d8_en), .ts_dout_cnt(d8_cnt)
  );

  always #5 clk_main = ~clk_main;

  always @(posedge clk_main) cyc <= cyc + 1;

  always @(negedge clk_main) begin
    if (d4_en === 1'b1) begin
      q4_dat.push_back(d4_dout);
      q4_cnt.push_back(d4_cnt);
      q4_cyc.push_back(cyc);
    end
    if (d8_en === 1'b1) begin
      q8_dat.push_back(d8_dout);
      q8_cnt.push_back(d8_cnt);
    end
  end

  task automatic send(input logic [8:0] v);
    @(negedge clk_main);
    ts_din    = v;
    ts_din_en = 1'b1;
    last_cyc  = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_main);
      ts_din    = '0;
      ts_din_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_main);
    ts_din_en = 1'b0;
    ts_din    = '0;
    rst_n     = 1'b0;
    @(negedge clk_main);
    @(negedge clk_main);
    rst_n = 1'b1;
    @(negedge clk_main);
    q4_dat.delete(); q4_cnt.delete(); q4_cyc.delete();
    q8_dat.delete(); q8_cnt.delete();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    #1;
    checks++; if (d4_dout !== 33'h0) begin errors++; $display("FAIL reset_dout4: got %h want 0", d4_dout); end
    checks++; if (d4_en !== 1'b0) begin errors++; $display("FAIL reset_en4: got %b want 0", d4_en); end
    checks++; if (d4_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt4: got %0d want 0", d4_cnt); end
    checks++; if (d8_dout !== 65'h0) begin errors++; $display("FAIL reset_dout8: got %h want 0", d8_dout); end
    checks++; if (d8_en !== 1'b0) begin errors++; $display("FAIL reset_en8: got %b want 0", d8_en); end
    checks++; if (d8_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt8: got %0d want 0", d8_cnt); end
    #100;
    checks++; if (q4_dat.size() != 0) begin errors++; $display("FAIL reset_idle_strobes4: got %0d want 0", q4_dat.size()); end
    checks++; if (q8_dat.size() != 0) begin errors++; $display("FAIL reset_idle_strobes8: got %0d want 0", q8_dat.size()); end
  endtask

  task automatic test_two_words();
    int c4, c8;
    do_reset();
    send(9'h101); send(9'h000); send(9'h010); send(9'h001); c4 = last_cyc;
    send(9'h0c0); send(9'h012); send(9'h008); send(9'h002); c8 = last_cyc;
    idle(5);
    checks++; if (q4_dat.size() != 2) begin errors++; $display("FAIL two_words_count: got %0d want 2", q4_dat.size()); end
    checks++; if (q4_dat.size() < 1 || q4_dat[0] !== 33'h1_01001001) begin errors++; $display("FAIL two_words_w1: got %h want 101001001", (q4_dat.size() > 0) ? q4_dat[0] : 'x); end
    checks++; if (q4_cnt.size() < 1 || q4_cnt[0] !== 3'd4) begin errors++; $display("FAIL two_words_c1: got %0d want 4", (q4_cnt.size() > 0) ? q4_cnt[0] : 'x); end
    checks++; if (q4_cyc.size() < 1 || q4_cyc[0] != c4 + 1) begin errors++; $display("FAIL two_words_t1: got cycle %0d want %0d", (q4_cyc.size() > 0) ? q4_cyc[0] : -1, c4 + 1); end
    checks++; if (q4_dat.size() < 2 || q4_dat[1] !== 33'h0_C0120802) begin errors++; $display("FAIL two_words_w2: got %h want 0c0120802", (q4_dat.size() > 1) ? q4_dat[1] : 'x); end
    checks++; if (q4_cnt.size() < 2 || q4_cnt[1] !== 3'd4) begin errors++; $display("FAIL two_words_c2: got %0d want 4", (q4_cnt.size() > 1) ? q4_cnt[1] : 'x); end
    checks++; if (q4_cyc.size() < 2 || q4_cyc[1] != c8 + 1) begin errors++; $display("FAIL two_words_t2: got cycle %0d want %0d", (q4_cyc.size() > 1) ? q4_cyc[1] : -1, c8 + 1); end
    checks++; if (d4_dout !== 33'h0_C0120802 || d4_cnt !== 3'd4 || d4_en !== 1'b0) begin
      errors++; $display("FAIL two_words_hold: got %h/%0d/%b want 0c0120802/4/0", d4_dout, d4_cnt, d4_en);
    end
  endtask

  task automatic test_idle_flush();
    int c2;
    do_reset();
    send(9'h04e); send(9'h020); c2 = last_cyc;
    idle(6);
`ifdef TS_PACK_FLUSH_EN
    checks++; if (q4_dat.size() != 1) begin errors++; $display("FAIL idle_flush_count: got %0d want 1", q4_dat.size()); end
    checks++; if (q4_dat.size() < 1 || q4_dat[0] !== 33'h0_4E200000) begin errors++; $display("FAIL idle_flush_word: got %h want 04e200000", (q4_dat.size() > 0) ? q4_dat[0] : 'x); end
    checks++; if (q4_cnt.size() < 1 || q4_cnt[0] !== 3'd2) begin errors++; $display("FAIL idle_flush_cnt: got %0d want 2", (q4_cnt.size() > 0) ? q4_cnt[0] : 'x); end
    checks++; if (q4_cyc.size() < 1 || q4_cyc[0] != c2 + 3) begin errors++; $display("FAIL idle_flush_time: got cycle %0d want %0d", (q4_cyc.size() > 0) ? q4_cyc[0] : -1, c2 + 3); end
`else
    checks++; if (q4_dat.size() != 0) begin errors++; $display("FAIL idle_hold_count: got %0d want 0 after last byte at cycle %0d", q4_dat.size(), c2); end
`endif
  endtask

  task automatic test_mid_word_start();
    int cs, ce;
    do_reset();
    send(9'h011); send(9'h022); send(9'h033);
    send(9'h147); cs = last_cyc;
    send(9'h050); send(9'h051); send(9'h052); ce = last_cyc;
    idle(4);
    checks++; if (q4_dat.size() != 2) begin errors++; $display("FAIL mid_start_count: got %0d want 2", q4_dat.size()); end
    checks++; if (q4_dat.size() < 1 || q4_dat[0] !== 33'h0_11223300) begin errors++; $display("FAIL mid_start_w1: got %h want 011223300", (q4_dat.size() > 0) ? q4_dat[0] : 'x); end
    checks++; if (q4_cnt.size() < 1 || q4_cnt[0] !== 3'd3) begin errors++; $display("FAIL mid_start_c1: got %0d want 3", (q4_cnt.size() > 0) ? q4_cnt[0] : 'x); end
    checks++; if (q4_cyc.size() < 1 || q4_cyc[0] != cs + 1) begin errors++; $display("FAIL mid_start_t1: got cycle %0d want %0d", (q4_cyc.size() > 0) ? q4_cyc[0] : -1, cs + 1); end
    checks++; if (q4_dat.size() < 2 || q4_dat[1] !== 33'h1_47505152) begin errors++; $display("FAIL mid_start_w2: got %h want 147505152", (q4_dat.size() > 1) ? q4_dat[1] : 'x); end
    checks++; if (q4_cnt.size() < 2 || q4_cnt[1] !== 3'd4) begin errors++; $display("FAIL mid_start_c2: got %0d want 4", (q4_cnt.size() > 1) ? q4_cnt[1] : 'x); end
    checks++; if (q4_cyc.size() < 2 || q4_cyc[1] != ce + 1) begin errors++; $display("FAIL mid_start_t2: got cycle %0d want %0d", (q4_cyc.size() > 1) ? q4_cyc[1] : -1, ce + 1); end
  endtask

  task automatic test_long_packet();
    do_reset();
    send(9'h047); send(9'h040); send(9'h001); send(9'h000);
    for (int i = 1; i <= 184; i++) send(9'(i));
    idle(4);
    checks++; if (q4_dat.size() != 47) begin errors++; $display("FAIL long_count: got %0d want 47", q4_dat.size()); end
    checks++; if (q4_dat.size() < 1 || q4_dat[0] !== 33'h0_47400100) begin errors++; $display("FAIL long_first: got %h want 047400100", (q4_dat.size() > 0) ? q4_dat[0] : 'x); end
    checks++; if (q4_dat.size() < 47 || q4_dat[46] !== 33'h0_B5B6B7B8) begin errors++; $display("FAIL long_last: got %h want 0b5b6b7b8", (q4_dat.size() > 46) ? q4_dat[46] : 'x); end
    for (int k = 0; k < q4_dat.size(); k++) begin
      checks++;
      if (q4_cnt[k] !== 3'd4 || q4_dat[k][32] !== 1'b0) begin
        errors++; $display("FAIL long_word%0d: got cnt %0d flag %b want cnt 4 flag 0", k, q4_cnt[k], q4_dat[k][32]);
      end
      if (k > 0) begin
        checks++;
        if (q4_cyc[k] - q4_cyc[k-1] != 4) begin
          errors++; $display("FAIL long_spacing%0d: got %0d cycles want 4", k, q4_cyc[k] - q4_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    send(9'h0aa); send(9'h0bb);
    @(negedge clk_main);
    ts_din_en = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk_main);
    checks++; if (d4_dout !== 33'h0 || d4_en !== 1'b0 || d4_cnt !== 3'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%b/%0d want 0/0/0", d4_dout, d4_en, d4_cnt);
    end
    rst_n = 1'b1;
    send(9'h011); send(9'h022); send(9'h033); send(9'h044);
    idle(4);
    checks++; if (q4_dat.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d want 1", q4_dat.size()); end
    checks++; if (q4_dat.size() < 1 || q4_dat[0] !== 33'h0_11223344) begin errors++; $display("FAIL midreset_word: got %h want 011223344", (q4_dat.size() > 0) ? q4_dat[0] : 'x); end
    checks++; if (q4_cnt.size() < 1 || q4_cnt[0] !== 3'd4) begin errors++; $display("FAIL midreset_cnt: got %0d want 4", (q4_cnt.size() > 0) ? q4_cnt[0] : 'x); end
  endtask

  task automatic test_width8();
    do_reset();
    send(9'h101); send(9'h000); send(9'h010); send(9'h001);
    send(9'h0c0); send(9'h012); send(9'h008); send(9'h002);
    idle(4);
    checks++; if (q8_dat.size() != 1) begin errors++; $display("FAIL width8_count: got %0d want 1", q8_dat.size()); end
    checks++; if (q8_dat.size() < 1 || q8_dat[0] !== 65'h1_01001001C0120802) begin errors++; $display("FAIL width8_word: got %h want 101001001c0120802", (q8_dat.size() > 0) ? q8_dat[0] : 'x); end
    checks++; if (q8_cnt.size() < 1 || q8_cnt[0] !== 4'd8) begin errors++; $display("FAIL width8_cnt: got %0d want 8", (q8_cnt.size() > 0) ? q8_cnt[0] : 'x); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_idle_flush();
    test_mid_word_start();
    test_long_packet();
    test_reset_mid_word();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
